// File: rtl/compare_9_8_7_pkg.sv
// Shared constants and helpers for the (9,8,7) residue-number-system comparator.
package compare_9_8_7_pkg;
    localparam int MOD1    = 9;
    localparam int MOD2    = 8;
    localparam int MOD3    = 7;
    localparam int W1      = 4;
    localparam int W2      = 3;
    localparam int W3      = 3;
    localparam int RANGE   = 504;
    localparam int INV9_M8 = 1;
    localparam int INV9_M7 = 4;
    localparam int INV8_M7 = 1;

    // Bounded repeated subtraction; operands here never exceed 63.
    function automatic logic [2:0] mod7(input logic [5:0] v);
        logic [5:0] r;
        r = v;
        for (int i = 0; i < 9; i++) begin
            if (r >= 6'd7) r = r - 6'd7;
        end
        return r[2:0];
    endfunction
endpackage

// File: rtl/compare_9_8_7_rns_to_mrc.sv
// Converts one residue triple into mixed-radix digits (a1, a2, a3), value = a1 + 9*a2 + 72*a3.
module rns_to_mrc
    import compare_9_8_7_pkg::*;
#(
    parameter int M1 = MOD1,
    parameter int M2 = MOD2,
    parameter int M3 = MOD3
) (
    input  logic [W1-1:0] r1,
    input  logic [W2-1:0] r2,
    input  logic [W3-1:0] r3,
    output logic [W1-1:0] a1,
    output logic [W2-1:0] a2,
    output logic [W3-1:0] a3,
    output logic          valid
);
    logic [4:0] d2;
    logic [5:0] d3;
    logic [2:0] t3;
    logic [5:0] u3;
    logic [5:0] v3;

    assign a1 = r1;

    // Bias by 8 so (r2 - a1) stays non-negative; the low 3 bits are the mod-8 result.
    assign d2 = 5'(r2) + 5'd8 - 5'(r1);
    assign a2 = d2[2:0] & 3'(INV9_M8 * 7);

    // Bias by 14 (a multiple of 7) so (r3 - a1) stays non-negative before reduction.
    assign d3 = 6'(r3) + 6'd14 - 6'(r1);
    assign t3 = mod7(d3);
    assign u3 = 6'(INV9_M7) * 6'(t3);
    assign v3 = u3 + 6'd7 - 6'(a2);
    assign a3 = mod7(6'(INV8_M7) * v3);

    assign valid = (32'(r1) < M1) && (32'(r2) < M2) && (32'(r3) < M3);
endmodule

// File: rtl/compare_9_8_7.sv
// Compares two RNS(9,8,7) operands: combinational le/eq/gr plus registered copies.
module compare_9_8_7
    import compare_9_8_7_pkg::*;
#(
    parameter int M1 = MOD1,
    parameter int M2 = MOD2,
    parameter int M3 = MOD3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W1-1:0] x1,
    input  logic [W2-1:0] x2,
    input  logic [W3-1:0] x3,
    input  logic [W1-1:0] y1,
    input  logic [W2-1:0] y2,
    input  logic [W3-1:0] y3,
    output logic          le,
    output logic          eq,
    output logic          gr,
    output logic          le_q,
    output logic          eq_q,
    output logic          gr_q
);
    localparam int KW = W1 + W2 + W3;

    logic [W1-1:0] xa1, ya1;
    logic [W2-1:0] xa2, ya2;
    logic [W3-1:0] xa3, ya3;
    logic          xv, yv, ok;
    logic [KW-1:0] xk, yk;

    rns_to_mrc #(.M1(M1), .M2(M2), .M3(M3)) u_mrc_x (
        .r1(x1), .r2(x2), .r3(x3), .a1(xa1), .a2(xa2), .a3(xa3), .valid(xv)
    );
    rns_to_mrc #(.M1(M1), .M2(M2), .M3(M3)) u_mrc_y (
        .r1(y1), .r2(y2), .r3(y3), .a1(ya1), .a2(ya2), .a3(ya3), .valid(yv)
    );

    // Most-significant digit first, so a plain unsigned compare is lexicographic.
    assign xk = {xa3, xa2, xa1};
    assign yk = {ya3, ya2, ya1};
    assign ok = xv & yv;

    assign le = ok & (xk <  yk);
    assign eq = ok & (xk == yk);
    assign gr = ok & (xk >  yk);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            le_q <= 1'b0;
            eq_q <= 1'b0;
            gr_q <= 1'b0;
        end else begin
            le_q <= le;
            eq_q <= eq;
            gr_q <= gr;
        end
    end
endmodule

// File: tb/tb_compare_9_8_7.sv
// Directed bench for compare_9_8_7: hand vectors, value sweeps, invalid inputs and reset.
module tb_compare_9_8_7;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] x1 = '0, y1 = '0;
    logic [2:0] x2 = '0, x3 = '0, y2 = '0, y3 = '0;
    logic       le, eq, gr, le_q, eq_q, gr_q;
    int         checks = 0;
    int         errors = 0;

    compare_9_8_7 dut (
        .clk(clk), .rst_n(rst_n),
        .x1(x1), .x2(x2), .x3(x3), .y1(y1), .y2(y2), .y3(y3),
        .le(le), .eq(eq), .gr(gr), .le_q(le_q), .eq_q(eq_q), .gr_q(gr_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic set_res(input int a1, a2, a3, b1, b2, b3);
        x1 = 4'(a1); x2 = 3'(a2); x3 = 3'(a3);
        y1 = 4'(b1); y2 = 3'(b2); y3 = 3'(b3);
    endtask

    task automatic set_xy(input int x, input int y);
        set_res(x % 9, x % 8, x % 7, y % 9, y % 8, y % 7);
    endtask

    function automatic logic [2:0] ref_cmp(input int x, input int y);
        return {x < y, x == y, x > y};
    endfunction

    initial begin
        // Reset state
        set_xy(0, 252);
        #1;
        chk("reset_regs", {le_q, eq_q, gr_q}, 3'b000);
        chk("reset_comb", {le, eq, gr}, 3'b100);

        // Release with X=5, Y=9
        @(negedge clk);
        rst_n = 1'b1;
        set_xy(5, 9);
        @(posedge clk);
        #1;
        chk("first_edge", {le_q, eq_q, gr_q}, 3'b100);

        // Hand vectors
        set_res(0, 0, 0, 0, 4, 0); #1; chk("x0_y252", {le, eq, gr}, 3'b100);
        set_res(6, 3, 4, 6, 3, 4); #1; chk("x123_eq", {le, eq, gr}, 3'b010);
        set_res(8, 3, 6, 0, 0, 0); #1; chk("x251_y0", {le, eq, gr}, 3'b001);
        set_res(8, 7, 6, 7, 6, 5); #1; chk("x503_y502", {le, eq, gr}, 3'b001);
        set_res(7, 6, 5, 8, 7, 6); #1; chk("x502_y503", {le, eq, gr}, 3'b100);
        set_res(8, 7, 6, 8, 7, 6); #1; chk("x503_eq", {le, eq, gr}, 3'b010);
        set_res(0, 0, 0, 8, 7, 6); #1; chk("x0_y503", {le, eq, gr}, 3'b100);
        set_res(8, 7, 6, 0, 0, 0); #1; chk("x503_y0", {le, eq, gr}, 3'b001);

        // Registered path follows the combinational result one edge later
        @(negedge clk);
        set_res(8, 3, 6, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("reg_gr", {le_q, eq_q, gr_q}, 3'b001);

        // Invalid inputs
        set_res(5, 5, 7, 0, 0, 0); #1; chk("inv_x3", {le, eq, gr}, 3'b000);
        set_res(5, 5, 5, 9, 0, 0); #1; chk("inv_y1", {le, eq, gr}, 3'b000);
        set_res(9, 1, 2, 0, 0, 0); #1; chk("inv_x1", {le, eq, gr}, 3'b000);
        set_res(0, 0, 0, 1, 1, 7); #1; chk("inv_y3", {le, eq, gr}, 3'b000);
        @(posedge clk);
        #1;
        chk("inv_reg", {le_q, eq_q, gr_q}, 3'b000);

        // Sweeps
        for (int i = 0; i < 252; i++) begin
            set_xy(i, i); #1; chk("sweep_eq", {le, eq, gr}, 3'b010);
        end
        for (int i = 0; i < 252; i++) begin
            set_xy(i, 252 - i); #1; chk("sweep_up", {le, eq, gr}, ref_cmp(i, 252 - i));
        end
        for (int i = 0; i < 252; i++) begin
            set_xy(251 - i, i); #1; chk("sweep_dn", {le, eq, gr}, ref_cmp(251 - i, i));
        end
        for (int i = 0; i < 504; i += 37) begin
            set_xy(0, i);   #1; chk("bnd_x0",   {le, eq, gr}, ref_cmp(0, i));
            set_xy(503, i); #1; chk("bnd_x503", {le, eq, gr}, ref_cmp(503, i));
        end

        // Mid-run asynchronous reset
        @(negedge clk);
        set_xy(300, 10);
        @(posedge clk);
        #1;
        chk("pre_rst_reg", {le_q, eq_q, gr_q}, 3'b001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst", {le_q, eq_q, gr_q}, 3'b000);
        chk("midrun_comb", {le, eq, gr}, 3'b001);
        @(negedge clk);
        rst_n = 1'b1;
        set_xy(5, 9);
        @(posedge clk);
        #1;
        chk("rerelease", {le_q, eq_q, gr_q}, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/compare_9_8_7.md
COMPARE_9_8_7 -- requirements
Module: compare_9_8_7

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 Parameter M1, default 9, SHALL be the modulus of residue channel 1.
REQ-003 Parameter M2, default 8, SHALL be the modulus of residue channel 2.
REQ-004 Parameter M3, default 7, SHALL be the modulus of residue channel 3.
REQ-005 Port clk, input, 1 bit, SHALL be the clock.
REQ-006 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-007 Port x1, input, 4 bits, SHALL carry X mod 9.
REQ-008 Port x2, input, 3 bits, SHALL carry X mod 8.
REQ-009 Port x3, input, 3 bits, SHALL carry X mod 7.
REQ-010 Ports y1, y2 and y3, inputs of 4, 3 and 3 bits, SHALL carry Y mod 9, Y mod 8 and Y mod 7.
REQ-011 Ports le, eq and gr, outputs of 1 bit each, SHALL be combinational and mean X<Y, X==Y and X>Y.
REQ-012 Ports le_q, eq_q and gr_q, outputs of 1 bit each, SHALL be registered copies of le, eq and gr.
REQ-013 Port order SHALL be: clk, rst_n, x1, x2, x3, y1, y2, y3, le, eq, gr, le_q, eq_q, gr_q.

Function
REQ-014 X and Y SHALL be the unique integers in [0,503] whose residues are the input triples.
REQ-015 Each operand SHALL be converted to mixed-radix digits: a1=r1; a2=(r2-a1) mod 8; a3=(4*(r3-a1)-a2) mod 7.
REQ-016 Because the operand value equals a1 + 9*a2 + 72*a3, the comparison SHALL be lexicographic on (a3, a2, a1).
REQ-017 All mod-8 and mod-7 arithmetic SHALL produce a non-negative result in [0, m-1], including negative intermediates.
REQ-018 For valid inputs, exactly one of le, eq, gr SHALL be 1.
REQ-019 An input is invalid if x1>8, x3==7, y1>8 or y3==7; any invalid input SHALL force le=eq=gr=0.
REQ-020 le, eq and gr SHALL have zero-cycle latency: purely combinational from x*/y*, with no dependence on clk.
REQ-021 le_q, eq_q and gr_q SHALL take the values of le, eq and gr at each rising clk edge, giving one-cycle latency.
REQ-022 Boundary values X=0 and X=503 SHALL compare correctly against any Y.

Reset
REQ-023 While rst_n=0, le_q, eq_q and gr_q SHALL be 0 immediately, independent of clk.
REQ-024 The combinational outputs le, eq and gr SHALL be unaffected by rst_n.
REQ-025 The first rising clk edge after rst_n deasserts SHALL load the current comparison result into the registered outputs.

Structure
REQ-026 A shared package SHALL hold: moduli 9, 8, 7; channel widths 4, 3, 3; dynamic range 504; inverse constants inv(9) mod 8 = 1, inv(9) mod 7 = 4, inv(8) mod 7 = 1.
REQ-027 One sub-module, rns_to_mrc, SHALL map (r1, r2, r3) to (a1, a2, a3) plus a valid flag, and SHALL be instantiated once per operand.
REQ-028 The top level SHALL contain only the digit comparator, the invalid-input masking and the output registers.

Verification
REQ-029 X=0 (0,0,0), Y=252 (0,4,0) -> le=1, eq=0, gr=0.
REQ-030 X=Y=123 (6,3,4) -> eq=1 only; a sweep of X=Y=i for i=0..251 -> eq=1 for every i.
REQ-031 X=251 (8,3,6), Y=0 (0,0,0) -> gr=1; X=503 (8,7,6), Y=502 (7,6,5) -> gr=1.
REQ-032 The following sweeps SHALL match integer comparison at every point:
- X=i, Y=252-i for i=0..251 (stage crosses eq at i=126);
- X=251-i, Y=i for i=0..251.
REQ-033 x3=7 or y1=9 with otherwise valid inputs -> le=eq=gr=0.
REQ-034 Reset check:
- assert rst_n=0 mid-run -> le_q=eq_q=gr_q=0 immediately;
- release reset with X=5, Y=9 -> le_q=1 after the first rising clk edge.
